rvc_asap_5pl_dmem_arb: RTL and testbench
========================================

Name: rvc_asap_5pl_dmem_arb

Overview:
- Two-requester arbiter in front of the shared data-memory port (D_MEM / CR_MEM / VGA regions) of the 5-stage core.
- The core's load/store at Q103H has priority. A second master, the external loader/debug port, gets the port when the core is idle, or is forced in by a starvation counter.
- Outputs drive the memory wrapper's AluOut/RegRdData2/ByteEn/WrEn/SelDMemWb/SignExt inputs.
- Routes the Q104H read data back to whichever master issued the read.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles an ext request may be denied before it is force-granted; legal range 1..15.
- CNT_W, 4: starvation counter width; must satisfy 2**CNT_W > STARVE_LIMIT.

Ports:
- Clock  in  1  core clock
- Rst  in  1  synchronous, active-low reset
- CoreReqQ103H  in  1  core memory access valid this cycle
- CoreWrEn  in  1  1 = store, 0 = load
- CoreAddr  in  32  byte address (AluOut)
- CoreWrData  in  32  store data (RegRdData2)
- CoreByteEn  in  4  byte enables
- CoreSignExt  in  1  sign-extend load
- CoreStall  out  1  core must hold Q103H and retry next cycle
- CoreRdDataQ104H  out  32  load data for core
- ExtReq  in  1  ext access request; held until ExtGnt
- ExtWrEn  in  1  1 = write
- ExtAddr  in  32  byte address
- ExtWrData  in  32  write data
- ExtByteEn  in  4  byte enables
- ExtGnt  out  1  request accepted this cycle
- ExtRdData  out  32  read data
- ExtRdValid  out  1  ExtRdData valid (one cycle)
- MemAddr  out  32  to wrapper AluOut
- MemWrData  out  32  to wrapper RegRdData2
- MemByteEn  out  4  to wrapper CtrlDMemByteEn
- MemWrEn  out  1  to wrapper CtrlDMemWrEn
- MemRdEn  out  1  to wrapper SelDMemWb
- MemSignExt  out  1  to wrapper CtrlSignExt
- MemRdDataQ104H  in  32  from wrapper DMemRdDataQ104H

Behaviour:
- Grant decision is combinational in the request cycle. Memory read latency is 1 cycle; data returns the cycle after grant.
- State machine, two states:
  - ARB_NORM: core wins any conflict.
  - ARB_FORCE: ext wins this cycle.
- In ARB_NORM:
  - CoreReqQ103H=1: core granted, CoreStall=0. If ExtReq=1 in the same cycle, StarveCnt increments.
  - CoreReqQ103H=0 and ExtReq=1: ext granted, ExtGnt=1, StarveCnt cleared.
  - StarveCnt reaching STARVE_LIMIT with ExtReq=1: next state ARB_FORCE.
- In ARB_FORCE:
  - ExtGnt=1 unconditionally (ExtReq is guaranteed high).
  - CoreStall = CoreReqQ103H.
  - StarveCnt cleared; next state ARB_NORM.
- ExtReq dropping while counting (protocol violation; not expected): StarveCnt cleared, stay in ARB_NORM.
- StarveCnt saturates at STARVE_LIMIT; never wraps.
- Mem outputs:
  - Driven from the granted master.
  - MemWrEn / MemRdEn = granted master's WrEn / ~WrEn.
  - MemSignExt = CoreSignExt for core, 0 for ext.
  - No grant: all Mem outputs 0.
- Read return: the cycle after a granted load, RdOwner flop holds NONE/CORE/EXT.
  - EXT: ExtRdValid=1, ExtRdData=MemRdDataQ104H.
  - CORE: CoreRdDataQ104H=MemRdDataQ104H; otherwise 0.
  - Writes set RdOwner to NONE.
- Back-to-back grants of alternating owners are legal every cycle; RdOwner updates each cycle.
- Reset (Rst=0 at a rising Clock edge):
  - State=ARB_NORM, StarveCnt=0, RdOwner=NONE.
  - ExtRdValid=0, ExtRdData=0, CoreRdDataQ104H=0.
  - ExtGnt, CoreStall and Mem outputs are 0 while Rst=0.
  - A read in flight when reset asserts is dropped; no valid pulse is produced.
- CoreStall is never asserted in two consecutive cycles; the core is guaranteed at least 1 of every STARVE_LIMIT+1 cycles.

Decomposition:
- Shared package rvc_asap_pkg gets:
  - t_arb_state enum {ARB_NORM, ARB_FORCE}
  - t_rd_owner enum {OWN_NONE, OWN_CORE, OWN_EXT}
  - DEFAULT_STARVE_LIMIT
- Single module; flops use the standard reset-flop macros. No sub-module needed.
- Instantiated between the 5pl core and rvc_asap_5pl_mem_wrap.

Test Plan:
- Reset with ExtReq=1, CoreReqQ103H=1, Rst=0 for 3 cycles -> ExtGnt=0, CoreStall=0, MemWrEn=0, ExtRdValid=0 throughout.
- Core idle; ext write addr 0x0000_1004, data 0xDEADBEEF, ByteEn 4'hF; then ext read of the same address -> ExtGnt high one cycle each; ExtRdValid=1 one cycle later with ExtRdData=0xDEADBEEF.
- CoreReqQ103H=1 continuously and ExtReq=1, STARVE_LIMIT=4 -> ExtGnt=0 for cycles 1-4, ExtGnt=1 and CoreStall=1 in cycle 5, core granted again in cycle 6; pattern repeats every 5 cycles.
- Alternating core load from 0x1000 and ext load from 0x1008 in consecutive cycles, memory preloaded 0x11111111 / 0x22222222 -> CoreRdDataQ104H=0x11111111 and ExtRdData=0x22222222, each in the correct following cycle with no crossover.
- Ext load granted, then Rst=0 in the next cycle -> ExtRdValid stays 0; after release, State=ARB_NORM and StarveCnt=0 (first conflict needs a full 4 denials).
- Core load with CoreSignExt=1 and ByteEn 4'b0001 while ExtReq=0 -> MemSignExt=1, MemByteEn=4'b0001, MemRdEn=1, ExtGnt=0.

Source files
------------

// File: rtl/rvc_asap_5pl_dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rvc_asap_5pl_dmem_arb_pkg;

    // Arbitration mode: normal (core wins) or forced (ext wins this cycle)
    typedef enum logic {
        ARB_NORM  = 1'b0,
        ARB_FORCE = 1'b1
    } t_arb_state;

    // Which master the read data returning in Q104H belongs to
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } t_rd_owner;

    localparam int DEFAULT_STARVE_LIMIT = 4;
    localparam int DEFAULT_CNT_W        = 4;

endpackage

// File: rtl/rvc_asap_5pl_dmem_arb.sv
// Core/ext arbiter for the shared data-memory port; read data returned to issuing master.
// Latency: grant combinational in request cycle; read data one cycle after grant.
// Backpressure: ext waits (held ExtReq) while core busy; core stalled one cycle when ext is force-granted.
module rvc_asap_5pl_dmem_arb
    import rvc_asap_5pl_dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic        i_Clock,
    input  logic        i_Rst,
    // core side
    input  logic        i_CoreReqQ103H,
    input  logic        i_CoreWrEn,
    input  logic [31:0] i_CoreAddr,
    input  logic [31:0] i_CoreWrData,
    input  logic [3:0]  i_CoreByteEn,
    input  logic        i_CoreSignExt,
    output logic        o_CoreStall,
    output logic [31:0] o_CoreRdDataQ104H,
    // ext loader / debug side
    input  logic        i_ExtReq,
    input  logic        i_ExtWrEn,
    input  logic [31:0] i_ExtAddr,
    input  logic [31:0] i_ExtWrData,
    input  logic [3:0]  i_ExtByteEn,
    output logic        o_ExtGnt,
    output logic [31:0] o_ExtRdData,
    output logic        o_ExtRdValid,
    // memory wrapper side
    output logic [31:0] o_MemAddr,
    output logic [31:0] o_MemWrData,
    output logic [3:0]  o_MemByteEn,
    output logic        o_MemWrEn,
    output logic        o_MemRdEn,
    output logic        o_MemSignExt,
    input  logic [31:0] i_MemRdDataQ104H
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    t_arb_state       r_state;
    t_rd_owner        r_rd_owner;
    logic [CNT_W-1:0] r_starve_cnt;

    logic             w_core_gnt;
    logic             w_ext_gnt;
    logic             w_core_stall;
    logic [CNT_W-1:0] w_cnt_inc;
    t_rd_owner        w_rd_owner_nxt;

    // Saturating increment so the counter can never wrap past the limit
    assign w_cnt_inc = (r_starve_cnt >= LIMIT) ? LIMIT : (r_starve_cnt + CNT_W'(1));

    // Grant decision: forced ext slot first, then core priority, then idle-slot ext; nothing in reset
    always_comb begin
        w_core_gnt   = 1'b0;
        w_ext_gnt    = 1'b0;
        w_core_stall = 1'b0;
        if (i_Rst) begin
            if (r_state == ARB_FORCE) begin
                w_ext_gnt    = 1'b1;
                w_core_stall = i_CoreReqQ103H;
            end else if (i_CoreReqQ103H) begin
                w_core_gnt = 1'b1;
            end else if (i_ExtReq) begin
                w_ext_gnt = 1'b1;
            end
        end
    end

    // Memory port mux from the granted master; all-zero when idle
    always_comb begin
        o_MemAddr    = '0;
        o_MemWrData  = '0;
        o_MemByteEn  = '0;
        o_MemWrEn    = 1'b0;
        o_MemRdEn    = 1'b0;
        o_MemSignExt = 1'b0;
        if (w_core_gnt) begin
            o_MemAddr    = i_CoreAddr;
            o_MemWrData  = i_CoreWrData;
            o_MemByteEn  = i_CoreByteEn;
            o_MemWrEn    = i_CoreWrEn;
            o_MemRdEn    = ~i_CoreWrEn;
            o_MemSignExt = i_CoreSignExt;
        end else if (w_ext_gnt) begin
            o_MemAddr    = i_ExtAddr;
            o_MemWrData  = i_ExtWrData;
            o_MemByteEn  = i_ExtByteEn;
            o_MemWrEn    = i_ExtWrEn;
            o_MemRdEn    = ~i_ExtWrEn;
        end
    end

    // Owner of next cycle's read data; writes and idle cycles return nothing
    always_comb begin
        w_rd_owner_nxt = OWN_NONE;
        if (w_core_gnt && !i_CoreWrEn) begin
            w_rd_owner_nxt = OWN_CORE;
        end else if (w_ext_gnt && !i_ExtWrEn) begin
            w_rd_owner_nxt = OWN_EXT;
        end
    end

    // Starvation FSM: count core-vs-ext conflicts, force one ext slot on reaching the limit
    always_ff @(posedge i_Clock) begin
        if (!i_Rst) begin
            r_state      <= ARB_NORM;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                ARB_FORCE: begin
                    r_state      <= ARB_NORM;
                    r_starve_cnt <= '0;
                end
                default: begin
                    if (i_CoreReqQ103H && i_ExtReq) begin
                        r_starve_cnt <= w_cnt_inc;
                        if (w_cnt_inc == LIMIT) begin
                            r_state <= ARB_FORCE;
                        end
                    end else begin
                        // ext served in an idle slot, or ext dropped its request
                        r_starve_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // Read-return owner flop
    always_ff @(posedge i_Clock) begin
        if (!i_Rst) begin
            r_rd_owner <= OWN_NONE;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    // Gating with i_Rst drops a read that was in flight when reset arrives
    assign o_ExtGnt          = w_ext_gnt;
    assign o_CoreStall       = w_core_stall;
    assign o_ExtRdValid      = i_Rst && (r_rd_owner == OWN_EXT);
    assign o_ExtRdData       = o_ExtRdValid ? i_MemRdDataQ104H : 32'h0;
    assign o_CoreRdDataQ104H = (i_Rst && (r_rd_owner == OWN_CORE)) ? i_MemRdDataQ104H : 32'h0;

endmodule

// File: tb/tb_rvc_asap_5pl_dmem_arb.sv
// Directed bench for the data-memory arbiter with a small behavioural memory.
// Latency: inputs driven after falling edge, outputs checked 1 time unit later.
// Backpressure: ext request held high across starvation windows.
module tb_rvc_asap_5pl_dmem_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we, core_sx, core_stall;
    logic [31:0] core_addr, core_wd, core_rd;
    logic [3:0]  core_be;
    logic        ext_req, ext_we, ext_gnt, ext_rd_vld;
    logic [31:0] ext_addr, ext_wd, ext_rd;
    logic [3:0]  ext_be;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic [3:0]  mem_be;
    logic        mem_we, mem_re, mem_sx;

    logic [31:0] mem [16];

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    rvc_asap_5pl_dmem_arb #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .i_Clock           (clk),
        .i_Rst             (rst_n),
        .i_CoreReqQ103H    (core_req),
        .i_CoreWrEn        (core_we),
        .i_CoreAddr        (core_addr),
        .i_CoreWrData      (core_wd),
        .i_CoreByteEn      (core_be),
        .i_CoreSignExt     (core_sx),
        .o_CoreStall       (core_stall),
        .o_CoreRdDataQ104H (core_rd),
        .i_ExtReq          (ext_req),
        .i_ExtWrEn         (ext_we),
        .i_ExtAddr         (ext_addr),
        .i_ExtWrData       (ext_wd),
        .i_ExtByteEn       (ext_be),
        .o_ExtGnt          (ext_gnt),
        .o_ExtRdData       (ext_rd),
        .o_ExtRdValid      (ext_rd_vld),
        .o_MemAddr         (mem_addr),
        .o_MemWrData       (mem_wd),
        .o_MemByteEn       (mem_be),
        .o_MemWrEn         (mem_we),
        .o_MemRdEn         (mem_re),
        .o_MemSignExt      (mem_sx),
        .i_MemRdDataQ104H  (mem_rd)
    );

    // Behavioural memory: byte-enabled writes, one-cycle registered reads
    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wd[8*b +: 8];
            end
        end
        if (mem_re) mem_rd <= mem[mem_addr[5:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_core(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be, input logic sx);
        core_req = req; core_we = we; core_addr = addr; core_wd = wd; core_be = be; core_sx = sx;
    endtask

    task automatic set_ext(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
        ext_req = req; ext_we = we; ext_addr = addr; ext_wd = wd; ext_be = be;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h1111_1111;   // 0x1000
        mem[2] = 32'h2222_2222;   // 0x1008
        mem_rd = 32'h0;
        rst_n  = 1'b0;
        set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_ext (1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset held 3 cycles with both masters requesting writes
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_core(1'b1, 1'b1, 32'h1000, 32'hAAAA_AAAA, 4'hF, 1'b0);
            set_ext (1'b1, 1'b1, 32'h1004, 32'hBBBB_BBBB, 4'hF);
            #1;
            chk("rst_extgnt",  {31'b0, ext_gnt},    32'h0);
            chk("rst_stall",   {31'b0, core_stall}, 32'h0);
            chk("rst_memwren", {31'b0, mem_we},     32'h0);
            chk("rst_extrdv",  {31'b0, ext_rd_vld}, 32'h0);
            chk("rst_corerd",  core_rd,             32'h0);
        end

        // Ext write then ext read of 0x1004 with core idle
        @(negedge clk);
        rst_n = 1'b1;
        set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_ext (1'b1, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
        #1;
        chk("extwr_gnt",   {31'b0, ext_gnt}, 32'h1);
        chk("extwr_wren",  {31'b0, mem_we},  32'h1);
        chk("extwr_addr",  mem_addr,         32'h0000_1004);
        @(negedge clk);
        set_ext(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'hF);
        #1;
        chk("extrd_gnt",   {31'b0, ext_gnt},    32'h1);
        chk("extrd_rden",  {31'b0, mem_re},     32'h1);
        chk("extrd_vld0",  {31'b0, ext_rd_vld}, 32'h0);
        @(negedge clk);
        set_ext(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("extrd_gnt0",  {31'b0, ext_gnt},    32'h0);
        chk("extrd_vld",   {31'b0, ext_rd_vld}, 32'h1);
        chk("extrd_data",  ext_rd,              32'hDEAD_BEEF);

        // Continuous conflict: ext forced in every 5th cycle, core stalled only then
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            set_core(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b1);
            set_ext (1'b1, 1'b0, 32'h1008, 32'h0, 4'hF);
            #1;
            chk($sformatf("starve_gnt_c%0d", c),   {31'b0, ext_gnt},    {31'b0, (c % 5 == 0)});
            chk($sformatf("starve_stall_c%0d", c), {31'b0, core_stall}, {31'b0, (c % 5 == 0)});
            chk($sformatf("starve_sx_c%0d", c),    {31'b0, mem_sx},     {31'b0, (c % 5 != 0)});
            if (c == 2) chk("starve_corerd_c2", core_rd, 32'h1111_1111);
            if (c == 6) begin
                chk("starve_extvld_c6", {31'b0, ext_rd_vld}, 32'h1);
                chk("starve_extrd_c6",  ext_rd,              32'h2222_2222);
                chk("starve_corerd_c6", core_rd,             32'h0);
            end
        end

        // Alternating core load 0x1000 / ext load 0x1008 in consecutive cycles
        @(negedge clk);
        set_core(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);
        set_ext (1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("alt_a_coregnt", {31'b0, mem_re}, 32'h1);
        @(negedge clk);
        set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_ext (1'b1, 1'b0, 32'h1008, 32'h0, 4'hF);
        #1;
        chk("alt_b_extgnt", {31'b0, ext_gnt},    32'h1);
        chk("alt_b_corerd", core_rd,             32'h1111_1111);
        chk("alt_b_extvld", {31'b0, ext_rd_vld}, 32'h0);
        @(negedge clk);
        set_core(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);
        set_ext (1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("alt_c_extvld", {31'b0, ext_rd_vld}, 32'h1);
        chk("alt_c_extrd",  ext_rd,              32'h2222_2222);
        chk("alt_c_corerd", core_rd,             32'h0);
        @(negedge clk);
        set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        #1;
        chk("alt_d_corerd", core_rd,             32'h1111_1111);
        chk("alt_d_extvld", {31'b0, ext_rd_vld}, 32'h0);
        chk("alt_d_extrd",  ext_rd,              32'h0);

        // Ext load granted, then reset next cycle: the read return is dropped
        @(negedge clk);
        set_ext(1'b1, 1'b0, 32'h1008, 32'h0, 4'hF);
        #1;
        chk("rstrd_gnt", {31'b0, ext_gnt}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        set_ext(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("rstrd_vld", {31'b0, ext_rd_vld}, 32'h0);
        chk("rstrd_dat", ext_rd,              32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstrd_vld_after", {31'b0, ext_rd_vld}, 32'h0);

        // Build up 3 denials, reset, then a fresh conflict needs a full 4 denials
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            set_core(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);
            set_ext (1'b1, 1'b0, 32'h1008, 32'h0, 4'hF);
            #1;
            chk($sformatf("pre_gnt_c%0d", c), {31'b0, ext_gnt}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            #1;
            chk($sformatf("post_gnt_c%0d", c),   {31'b0, ext_gnt},    {31'b0, (c == 5)});
            chk($sformatf("post_stall_c%0d", c), {31'b0, core_stall}, {31'b0, (c == 5)});
            @(negedge clk);
        end

        // Core signed byte load while ext idle
        set_core(1'b1, 1'b0, 32'h1000, 32'h0, 4'b0001, 1'b1);
        set_ext (1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("sx_signext", {31'b0, mem_sx},     32'h1);
        chk("sx_byteen",  {28'b0, mem_be},     32'h1);
        chk("sx_rden",    {31'b0, mem_re},     32'h1);
        chk("sx_extgnt",  {31'b0, ext_gnt},    32'h0);
        chk("sx_stall",   {31'b0, core_stall}, 32'h0);

        @(negedge clk);
        set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
